muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide coprocessor; successor to the core's fixed 32-bit divider.
- Covers all eight RV32M ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) with a generic data width.
- Sits beside ex: ex issues a start pulse, holds the pipeline while busy_o is high, and writes result_o to reg_waddr_o on ready_o.
- kill_i aborts an operation on a jump flush.

---
 rtl/muldiv_if.sv | 27 ++
 rtl/muldiv_unit.sv | 225 ++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Issue/complete handshake between the ex stage and the muldiv_unit coprocessor.
// The ex side drives the master modport; the coprocessor uses the slave modport.
interface muldiv_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  start_i;
  logic [2:0]            op_i;
  logic [DATA_W-1:0]     opa_i;
  logic [DATA_W-1:0]     opb_i;
  logic [REG_ADDR_W-1:0] reg_waddr_i;
  logic                  kill_i;
  logic [DATA_W-1:0]     result_o;
  logic                  ready_o;
  logic                  busy_o;
  logic [REG_ADDR_W-1:0] reg_waddr_o;

  modport master (
    output start_i, op_i, opa_i, opb_i, reg_waddr_i, kill_i,
    input  result_o, ready_o, busy_o, reg_waddr_o
  );

  modport slave (
    input  start_i, op_i, opa_i, opb_i, reg_waddr_i, kill_i,
    output result_o, ready_o, busy_o, reg_waddr_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide coprocessor: shift-add multiply, restoring divide.
// Build option MULDIV_EARLY_OUT_EN lets multiplies stop once the remaining multiplier bits are zero.
module muldiv_unit #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 6   // 2**CNT_W must exceed DATA_W
) (
  input  logic      clk,
  input  logic      rst,
  muldiv_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FAST,
    S_DONE
  } state_t;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [DATA_W-1:0] MIN_NEG  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W-1);

  state_t                  r_state;
  state_t                  w_next;
  logic [2:0]              r_op;
  logic [2*DATA_W-1:0]     r_acc;
  logic [2*DATA_W-1:0]     r_mcand;
  logic [DATA_W-1:0]       r_b;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_neg_q;
  logic                    r_neg_r;
  logic [REG_ADDR_W-1:0]   r_waddr;
  logic                    r_ready;
  logic [DATA_W-1:0]       r_result;

  // ---------------------------------------------------------------------------
  // Operand decode at issue time
  // ---------------------------------------------------------------------------
  logic              w_is_div;
  logic              w_a_signed;
  logic              w_b_signed;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [DATA_W-1:0] w_abs_a;
  logic [DATA_W-1:0] w_abs_b;
  logic              w_div_zero;
  logic              w_ovf;
  logic              w_fast;
  logic              w_start;

  assign w_is_div   = bus.op_i[2];
  assign w_a_signed = (bus.op_i == OP_MULH) || (bus.op_i == OP_MULHSU) ||
                      (bus.op_i == OP_DIV)  || (bus.op_i == OP_REM);
  assign w_b_signed = (bus.op_i == OP_MULH) || (bus.op_i == OP_DIV) ||
                      (bus.op_i == OP_REM);
  assign w_a_neg    = w_a_signed && bus.opa_i[DATA_W-1];
  assign w_b_neg    = w_b_signed && bus.opb_i[DATA_W-1];
  assign w_abs_a    = w_a_neg ? -bus.opa_i : bus.opa_i;
  assign w_abs_b    = w_b_neg ? -bus.opb_i : bus.opb_i;
  assign w_div_zero = w_is_div && (bus.opb_i == '0);
  assign w_ovf      = ((bus.op_i == OP_DIV) || (bus.op_i == OP_REM)) &&
                      (bus.opa_i == MIN_NEG) && (bus.opb_i == '1);

`ifdef MULDIV_EARLY_OUT_EN
  assign w_fast = w_div_zero || w_ovf || (!w_is_div && (bus.opb_i == '0));
`else
  assign w_fast = w_div_zero || w_ovf;
`endif

  assign w_start = (r_state == S_IDLE) && bus.start_i && !bus.kill_i;

  // ---------------------------------------------------------------------------
  // One iteration step
  // ---------------------------------------------------------------------------
  logic [2*DATA_W:0]   w_div_shift;
  logic [DATA_W:0]     w_div_diff;
  logic                w_div_ge;
  logic [2*DATA_W-1:0] w_div_acc;
  logic                w_last;

  // Remainder lives in the upper half, quotient bits enter at the bottom as
  // dividend bits leave the top; the trial subtract needs one extra bit.
  assign w_div_shift = {r_acc, 1'b0};
  assign w_div_diff  = w_div_shift[2*DATA_W:DATA_W] - {1'b0, r_b};
  assign w_div_ge    = !w_div_diff[DATA_W];
  assign w_div_acc   = w_div_ge ? {w_div_diff[DATA_W-1:0], w_div_shift[DATA_W-1:1], 1'b1}
                                : w_div_shift[2*DATA_W-1:0];

`ifdef MULDIV_EARLY_OUT_EN
  assign w_last = (r_cnt == LAST_CNT) || (!r_op[2] && (r_b[DATA_W-1:1] == '0));
`else
  assign w_last = (r_cnt == LAST_CNT);
`endif

  // ---------------------------------------------------------------------------
  // Final sign fix-up and result select
  // ---------------------------------------------------------------------------
  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0]   w_acc_lo;
  logic [DATA_W-1:0]   w_acc_hi;
  logic [DATA_W-1:0]   w_quo;
  logic [DATA_W-1:0]   w_rem;
  logic [DATA_W-1:0]   w_final;

  assign w_acc_lo = r_acc[DATA_W-1:0];
  assign w_acc_hi = r_acc[2*DATA_W-1:DATA_W];
  assign w_prod   = r_neg_q ? -r_acc : r_acc;
  assign w_quo    = r_neg_q ? -w_acc_lo : w_acc_lo;
  assign w_rem    = r_neg_r ? -w_acc_hi : w_acc_hi;

  // NOTE: every signal assigned in an always_comb gets a default first so no
  // path through the block leaves it unassigned and infers a latch.
  always_comb begin
    w_final = w_quo;
    case (r_op)
      OP_MUL:                       w_final = w_prod[DATA_W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod[2*DATA_W-1:DATA_W];
      OP_DIV, OP_DIVU:              w_final = w_quo;
      OP_REM, OP_REMU:              w_final = w_rem;
      default:                      w_final = w_quo;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_next = w_fast ? S_FAST : S_CALC;
      S_CALC: begin
        if (bus.kill_i)  w_next = S_IDLE;
        else if (w_last) w_next = S_DONE;
      end
      S_FAST: w_next = bus.kill_i ? S_IDLE : S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  // NOTE: all datapath flops are reset (not just control) so outputs are
  // defined zero straight out of reset and after an aborted operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op     <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_waddr  <= '0;
      r_ready  <= 1'b0;
      r_result <= '0;
    end else begin
      // ready/result are registered out of DONE, so kill cannot cancel them
      r_ready  <= (r_state == S_DONE);
      r_result <= (r_state == S_DONE) ? w_final : '0;

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_op    <= bus.op_i;
            r_waddr <= bus.reg_waddr_i;
            r_cnt   <= '0;
            r_b     <= w_is_div ? bus.opb_i : w_abs_b;
            r_mcand <= {{DATA_W{1'b0}}, w_abs_a};
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            if (w_div_zero) begin
              r_acc   <= {bus.opa_i, {DATA_W{1'b1}}};
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
            end else if (w_ovf) begin
              r_acc   <= {{DATA_W{1'b0}}, bus.opa_i};
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
            end else if (w_is_div) begin
              r_acc   <= {{DATA_W{1'b0}}, w_abs_a};
              r_b     <= w_abs_b;
            end else begin
              r_acc   <= '0;
            end
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_op[2]) begin
            r_acc <= w_div_acc;
          end else begin
            if (r_b[0]) r_acc <= r_acc + r_mcand;
            r_mcand <= {r_mcand[2*DATA_W-2:0], 1'b0};
            r_b     <= {1'b0, r_b[DATA_W-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o      = (r_state == S_CALC) || (r_state == S_FAST);
  assign bus.ready_o     = r_ready;
  assign bus.result_o    = r_result;
  assign bus.reg_waddr_o = r_waddr;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, randomized ops
// against a plain-arithmetic reference model, kill/restart/reset scenarios.
module tb_muldiv_unit;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  muldiv_if #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) bus ();

  muldiv_unit #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // ---------------------------------------------------------------------------
  // Reference model: RV32M semantics via native 64-bit arithmetic
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] ref_result(input logic [2:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    int          sa;
    int          sb;
    longint      p;
    logic [63:0] u;
    logic        ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: return a * b;
      3'd1: begin p = longint'(sa) * longint'(sb);          return p[63:32]; end
      3'd2: begin p = longint'(sa) * longint'({32'b0, b});  return p[63:32]; end
      3'd3: begin u = {32'b0, a} * {32'b0, b};              return u[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf)    return a;
        return sa / sb;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf)    return 32'h0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Cycles from the accepting edge to the ready_o cycle
  function automatic int ref_latency(input logic [2:0] op,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
    if (op[2] && b == 0) return 2;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
`ifdef MULDIV_EARLY_OUT_EN
    if (!op[2]) begin
      logic [31:0] m;
      m = (op == 3'd1 && b[31]) ? -b : b;
      if (m == 0) return 2;
      for (int i = 31; i >= 0; i--) if (m[i]) return 2 + i;
    end
`endif
    return DATA_W + 1;
  endfunction

  // Issues one op (caller is at a negedge) and returns at the negedge of the
  // ready_o cycle; lat = -1 if ready_o never came.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wa, output logic [31:0] res, output int lat,
                        output logic [4:0] wa_o);
    bit stray;
    stray = 1'b0;
    lat   = -1;
    res   = '0;
    wa_o  = '0;
    bus.op_i        = op;
    bus.opa_i       = a;
    bus.opb_i       = b;
    bus.reg_waddr_i = wa;
    bus.start_i     = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    total++;
    if (bus.busy_o !== 1'b1) begin
      bad++;
      $display("FAIL busy_after_start op=%0d got=%b want=1", op, bus.busy_o);
    end
    for (int k = 0; k < 100; k++) begin
      if (bus.ready_o === 1'b1) begin
        lat  = k;
        res  = bus.result_o;
        wa_o = bus.reg_waddr_o;
        break;
      end
      if (bus.result_o !== '0) stray = 1'b1;
      @(negedge clk);
    end
    total++;
    if (stray) begin
      bad++;
      $display("FAIL result_not_zero_before_ready op=%0d got=nonzero want=0", op);
    end
    total++;
    if (lat < 0) begin
      bad++;
      $display("FAIL ready_timeout op=%0d a=%h b=%h got=no_ready want=ready", op, a, b);
    end
  endtask

  task automatic test_reset();
    bus.start_i = 1'b0; bus.kill_i = 1'b0; bus.op_i = '0;
    bus.opa_i = '0; bus.opb_i = '0; bus.reg_waddr_i = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus.result_o !== '0)    begin bad++; $display("FAIL reset_result got=%h want=0", bus.result_o); end
    total++; if (bus.ready_o !== 1'b0)   begin bad++; $display("FAIL reset_ready got=%b want=0", bus.ready_o); end
    total++; if (bus.busy_o !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy_o); end
    total++; if (bus.reg_waddr_o !== '0) begin bad++; $display("FAIL reset_waddr got=%h want=0", bus.reg_waddr_o); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (bus.busy_o !== 1'b0)    begin bad++; $display("FAIL idle_busy got=%b want=0", bus.busy_o); end
  endtask

  task automatic test_directed();
    logic [2:0]  t_op  [10] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd0, 3'd1, 3'd2, 3'd3};
    logic [31:0] t_a   [10] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'h8000_0000,
                                32'h8000_0000, 32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] t_b   [10] = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF,
                                32'hFFFF_FFFF, 32'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] t_exp [10] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'h8000_0000,
                                32'h0, 32'd42, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    logic [31:0] res;
    logic [4:0]  wa_o;
    logic [4:0]  wa;
    int          lat;
    for (int i = 0; i < 10; i++) begin
      wa = (i == 0) ? 5'd5 : 5'(i + 10);
      run_op(t_op[i], t_a[i], t_b[i], wa, res, lat, wa_o);
      total++; if (res !== t_exp[i]) begin bad++; $display("FAIL dir%0d_result got=%h want=%h", i, res, t_exp[i]); end
      total++; if (lat != ref_latency(t_op[i], t_a[i], t_b[i])) begin
        bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, ref_latency(t_op[i], t_a[i], t_b[i]));
      end
      total++; if (wa_o !== wa) begin bad++; $display("FAIL dir%0d_waddr got=%0d want=%0d", i, wa_o, wa); end
      @(negedge clk);
      total++; if (bus.ready_o !== 1'b0 || bus.result_o !== '0) begin
        bad++; $display("FAIL dir%0d_ready_pulse_width got=%b/%h want=0/0", i, bus.ready_o, bus.result_o);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [4:0]  wa;
    logic [4:0]  wa_o;
    int          lat;
    int          sel;
    for (int i = 0; i < 40; i++) begin
      op  = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      wa  = 5'($urandom_range(0, 31));
      sel = int'($urandom_range(0, 7));
      if (sel == 0) b = 32'h0;
      if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (sel == 2) b = $urandom_range(1, 255);
      if (sel == 3) b = -($urandom_range(1, 255));
      run_op(op, a, b, wa, res, lat, wa_o);
      total++; if (res !== ref_result(op, a, b)) begin
        bad++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h got=%h want=%h", i, op, a, b, res, ref_result(op, a, b));
      end
      total++; if (lat != ref_latency(op, a, b)) begin
        bad++; $display("FAIL rnd%0d_latency op=%0d got=%0d want=%0d", i, op, lat, ref_latency(op, a, b));
      end
      total++; if (wa_o !== wa) begin bad++; $display("FAIL rnd%0d_waddr got=%0d want=%0d", i, wa_o, wa); end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    logic [4:0]  wa_o;
    int          lat;
    run_op(3'd1, 32'hFFFF_FFF0, 32'h0000_0003, 5'd1, res, lat, wa_o);
    total++; if (res !== ref_result(3'd1, 32'hFFFF_FFF0, 32'h3)) begin
      bad++; $display("FAIL b2b_first got=%h want=%h", res, ref_result(3'd1, 32'hFFFF_FFF0, 32'h3));
    end
    run_op(3'd6, 32'hFFFF_FF85, 32'd10, 5'd2, res, lat, wa_o);
    total++; if (res !== ref_result(3'd6, 32'hFFFF_FF85, 32'd10)) begin
      bad++; $display("FAIL b2b_second got=%h want=%h", res, ref_result(3'd6, 32'hFFFF_FF85, 32'd10));
    end
    total++; if (lat != ref_latency(3'd6, 32'hFFFF_FF85, 32'd10)) begin
      bad++; $display("FAIL b2b_second_latency got=%0d want=%0d", lat, ref_latency(3'd6, 32'hFFFF_FF85, 32'd10));
    end
    @(negedge clk);
  endtask

  task automatic test_kill();
    logic [31:0] res;
    logic [4:0]  wa_o;
    int          lat;
    int          seen;
    bus.op_i = 3'd4; bus.opa_i = 32'hFFFF_FFF9; bus.opb_i = 32'd2; bus.reg_waddr_i = 5'd5;
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (10) @(negedge clk);
    bus.kill_i = 1'b1;
    @(negedge clk);
    bus.kill_i = 1'b0;
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL kill_busy got=%b want=0", bus.busy_o); end
    run_op(3'd5, 32'd9, 32'd3, 5'd7, res, lat, wa_o);
    total++; if (res !== 32'd3) begin bad++; $display("FAIL kill_restart_result got=%h want=3", res); end
    total++; if (lat != DATA_W + 1) begin bad++; $display("FAIL kill_restart_latency got=%0d want=%0d", lat, DATA_W + 1); end
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.kill_i  = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.kill_i  = 1'b0;
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL kill_start_idle_busy got=%b want=0", bus.busy_o); end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.ready_o === 1'b1 || bus.busy_o === 1'b1) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL kill_start_idle_activity got=%0d want=0", seen); end
  endtask

  task automatic test_kill_done();
    int k;
    bus.op_i = 3'd5; bus.opa_i = 32'd1000; bus.opb_i = 32'd7; bus.reg_waddr_i = 5'd3;
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    k = 0;
    while (bus.busy_o === 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    total++; if (k != DATA_W) begin bad++; $display("FAIL done_entry_cycle got=%0d want=%0d", k, DATA_W); end
    bus.kill_i = 1'b1;
    @(negedge clk);
    bus.kill_i = 1'b0;
    total++; if (bus.ready_o !== 1'b1 || bus.result_o !== ref_result(3'd5, 32'd1000, 32'd7)) begin
      bad++; $display("FAIL kill_in_done got=%b/%h want=1/%h", bus.ready_o, bus.result_o, ref_result(3'd5, 32'd1000, 32'd7));
    end
    @(negedge clk);
  endtask

  task automatic test_restart_ignored();
    int k;
    bus.op_i = 3'd4; bus.opa_i = 32'hFFFF_FFF9; bus.opb_i = 32'd2; bus.reg_waddr_i = 5'd5;
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (4) @(negedge clk);
    bus.op_i = 3'd0; bus.opa_i = $urandom; bus.opb_i = $urandom; bus.reg_waddr_i = 5'd9;
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    total++; if (bus.reg_waddr_o !== 5'd5) begin bad++; $display("FAIL restart_waddr_mid got=%0d want=5", bus.reg_waddr_o); end
    k = 5;
    while (bus.ready_o !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    total++; if (k != DATA_W + 1) begin bad++; $display("FAIL restart_latency got=%0d want=%0d", k, DATA_W + 1); end
    total++; if (bus.result_o !== 32'hFFFF_FFFD) begin bad++; $display("FAIL restart_result got=%h want=fffffffd", bus.result_o); end
    total++; if (bus.reg_waddr_o !== 5'd5) begin bad++; $display("FAIL restart_waddr got=%0d want=5", bus.reg_waddr_o); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int seen;
    bus.op_i = 3'd4; bus.opa_i = 32'h1234_5678; bus.opb_i = 32'd13; bus.reg_waddr_i = 5'd5;
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (bus.busy_o !== 1'b0 || bus.ready_o !== 1'b0 || bus.result_o !== '0 || bus.reg_waddr_o !== '0) begin
      bad++; $display("FAIL reset_mid_outputs got=%b/%b/%h/%h want=0/0/0/0",
                      bus.busy_o, bus.ready_o, bus.result_o, bus.reg_waddr_o);
    end
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (45) begin
      @(negedge clk);
      if (bus.ready_o === 1'b1 || bus.busy_o === 1'b1) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL reset_mid_activity got=%0d want=0", seen); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_kill();
    test_kill_done();
    test_restart_ignored();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
